// File: rtl/pokemon_select_ctrl.sv
// rtl/pokemon_select_ctrl.sv - 2x4 creature-select cursor, blink and confirm controller
// Optional feature macro: SELECT_WRAP_EN (left/right wrap within the row).
module pokemon_select_ctrl #(
  parameter int BLINK_FRAMES   = 16,
  parameter int CONFIRM_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       chosen_ack,
  output logic [7:0] pokemon_id,
  output logic       highlight_on,
  output logic       chosen_valid,
  output logic [7:0] chosen_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BROWSE,
    S_CONFIRM,
    S_DONE
  } state_t;

  localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] CONFIRM_LAST = 8'(CONFIRM_FRAMES - 1);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [2:0] slot;
  logic [2:0] next_slot;
  logic       move_press;
  logic [7:0] next_id;

  // slot = id-1: bit 2 is the row, bits 1:0 the column; id 8 maps to slot 7
  assign slot       = pokemon_id[2:0] - 3'd1;
  assign move_press = btn_left | btn_right | btn_up | btn_down;
  assign next_id    = {5'd0, next_slot} + 8'd1;

  always_comb begin
    next_slot = slot;
    if (btn_left) begin
      if (slot[1:0] != 2'd0)
        next_slot = {slot[2], slot[1:0] - 2'd1};
`ifdef SELECT_WRAP_EN
      else
        next_slot = {slot[2], 2'd3};
`endif
    end else if (btn_right) begin
      if (slot[1:0] != 2'd3)
        next_slot = {slot[2], slot[1:0] + 2'd1};
`ifdef SELECT_WRAP_EN
      else
        next_slot = {slot[2], 2'd0};
`endif
    end else if (btn_up) begin
      next_slot = {1'b0, slot[1:0]};
    end else if (btn_down) begin
      next_slot = {1'b1, slot[1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      frame_cnt    <= 8'd0;
      pokemon_id   <= 8'd1;
      highlight_on <= 1'b0;
      chosen_valid <= 1'b0;
      chosen_id    <= 8'd0;
    end else if (!enable) begin
      state        <= S_IDLE;
      frame_cnt    <= 8'd0;
      highlight_on <= 1'b0;
      chosen_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state        <= S_BROWSE;
          frame_cnt    <= 8'd0;
          highlight_on <= 1'b1;
        end
        S_BROWSE: begin
          if (btn_enter) begin
            state        <= S_CONFIRM;
            chosen_id    <= pokemon_id;
            highlight_on <= 1'b1;
            frame_cnt    <= 8'd0;
          end else if (move_press) begin
            pokemon_id   <= next_id;
            highlight_on <= 1'b1;
            frame_cnt    <= 8'd0;
          end else if (frame_tick) begin
            if (frame_cnt >= BLINK_LAST) begin
              frame_cnt    <= 8'd0;
              highlight_on <= ~highlight_on;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        S_CONFIRM: begin
          if (frame_tick) begin
            if (frame_cnt >= CONFIRM_LAST) begin
              state        <= S_DONE;
              frame_cnt    <= 8'd0;
              chosen_valid <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
          if (chosen_ack) begin
            state        <= S_IDLE;
            chosen_valid <= 1'b0;
            highlight_on <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pokemon_select_ctrl.sv
// tb/tb_pokemon_select_ctrl.sv - randomized and directed bench against a grid-level reference model
module tb_pokemon_select_ctrl;
  localparam int BLINK   = 4;
  localparam int CONFIRM = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, enable = 1'b0, frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
  logic       chosen_ack = 1'b0;
  logic [7:0] pokemon_id, chosen_id;
  logic       highlight_on, chosen_valid;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: phase 0 idle, 1 browsing, 2 confirming, 3 done
  int m_phase = 0, m_id = 1, m_cid = 0, m_ticks = 0;
  logic m_hl = 1'b0, m_cv = 1'b0;

  pokemon_select_ctrl #(.BLINK_FRAMES(BLINK), .CONFIRM_FRAMES(CONFIRM)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_enter(btn_enter), .chosen_ack(chosen_ack),
    .pokemon_id(pokemon_id), .highlight_on(highlight_on),
    .chosen_valid(chosen_valid), .chosen_id(chosen_id)
  );

  always #5 clk = ~clk;

  function automatic int grid_move(int id, int dir);
    int row, col;
    row = (id - 1) / 4;
    col = (id - 1) % 4;
    case (dir)
      0: begin
        if (col > 0) col--;
`ifdef SELECT_WRAP_EN
        else col = 3;
`endif
      end
      1: begin
        if (col < 3) col++;
`ifdef SELECT_WRAP_EN
        else col = 0;
`endif
      end
      2: row = 0;
      default: row = 1;
    endcase
    return row * 4 + col + 1;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_id = 1; m_cid = 0; m_ticks = 0; m_hl = 0; m_cv = 0;
    end else if (!enable) begin
      m_phase = 0; m_ticks = 0; m_hl = 0; m_cv = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_ticks = 0; m_hl = 1;
    end else if (m_phase == 1) begin
      if (btn_enter) begin
        m_phase = 2; m_cid = m_id; m_hl = 1; m_ticks = 0;
      end else if (btn_left | btn_right | btn_up | btn_down) begin
        m_id = grid_move(m_id, btn_left ? 0 : btn_right ? 1 : btn_up ? 2 : 3);
        m_hl = 1; m_ticks = 0;
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks % BLINK == 0) m_hl = ~m_hl;
      end
    end else if (m_phase == 2) begin
      if (frame_tick) m_ticks++;
      if (m_ticks == CONFIRM) begin
        m_phase = 3; m_cv = 1; m_ticks = 0;
      end
    end else if (chosen_ack) begin
      m_phase = 0; m_cv = 0; m_hl = 0;
    end
  endtask

  // one clock with the given pulses; enable/rst_n are left as the caller set them
  task automatic cyc(input logic t, l, r, u, d, e, a);
    frame_tick = t; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
    btn_enter = e; chosen_ack = a;
    @(posedge clk);
    model_step();
    #1;
    frame_tick = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    btn_enter = 0; chosen_ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 1;
    cyc(1, 0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd1 || highlight_on !== 1'b0 || chosen_valid !== 1'b0 || chosen_id !== 8'd0) begin
      n_fails++;
      $display("FAIL reset: id=%0d hl=%0b cv=%0b cid=%0d, required id=1 hl=0 cv=0 cid=0",
               pokemon_id, highlight_on, chosen_valid, chosen_id);
    end
    rst_n = 1;
  endtask

  task automatic test_browse();
    int exp_ids[4] = '{2, 3, 4, 8};
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (highlight_on !== 1'b1) begin
      n_fails++;
      $display("FAIL browse_entry_hl: got %0b, required 1", highlight_on);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, i < 3, 0, i == 3, 0, 0);
      n_checks++;
      if (pokemon_id !== 8'(exp_ids[i]) || chosen_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL browse_move%0d: id=%0d cv=%0b, required id=%0d cv=0",
                 i, pokemon_id, chosen_valid, exp_ids[i]);
      end
    end
  endtask

  task automatic test_edges();
    int exp5;
`ifdef SELECT_WRAP_EN
    exp5 = 8;
`else
    exp5 = 5;
`endif
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd5) begin
      n_fails++;
      $display("FAIL edge_reach5: got %0d, required 5", pokemon_id);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'(exp5) || highlight_on !== 1'b1) begin
      n_fails++;
      $display("FAIL edge_left_col1: id=%0d hl=%0b, required id=%0d hl=1", pokemon_id, highlight_on, exp5);
    end
    if (exp5 == 8) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd1) begin
      n_fails++;
      $display("FAIL edge_up_from5: got %0d, required 1", pokemon_id);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd1) begin
      n_fails++;
      $display("FAIL edge_up_top: got %0d, required 1", pokemon_id);
    end
  endtask

  task automatic test_blink();
    int toggles = 0;
    logic prev;
    cyc(0, 0, 1, 0, 0, 0, 0);
    prev = highlight_on;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      if (highlight_on !== prev) toggles++;
      prev = highlight_on;
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (highlight_on !== prev) toggles++;
      prev = highlight_on;
    end
    n_checks++;
    if (toggles != 3 || highlight_on !== 1'b0) begin
      n_fails++;
      $display("FAIL blink_12ticks: toggles=%0d hl=%0b, required toggles=3 hl=0", toggles, highlight_on);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (highlight_on !== 1'b1) begin
      n_fails++;
      $display("FAIL blink_press: hl=%0b, required 1", highlight_on);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (highlight_on !== 1'b1) begin
      n_fails++;
      $display("FAIL blink_restart3: hl=%0b, required 1", highlight_on);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (highlight_on !== 1'b0) begin
      n_fails++;
      $display("FAIL blink_restart4: hl=%0b, required 0", highlight_on);
    end
  endtask

  task automatic go_to_six();
    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_confirm();
    go_to_six();
    cyc(1, 1, 0, 0, 0, 1, 0);
    n_checks++;
    if (chosen_id !== 8'd6 || pokemon_id !== 8'd6 || highlight_on !== 1'b1 || chosen_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL confirm_enter: cid=%0d id=%0d hl=%0b cv=%0b, required cid=6 id=6 hl=1 cv=0",
               chosen_id, pokemon_id, highlight_on, chosen_valid);
    end
    for (int i = 0; i < CONFIRM - 1; i++) cyc(1, i % 2, 0, 0, 0, i % 3 == 0, i == 5);
    n_checks++;
    if (chosen_valid !== 1'b0 || pokemon_id !== 8'd6 || chosen_id !== 8'd6) begin
      n_fails++;
      $display("FAIL confirm_29: cv=%0b id=%0d cid=%0d, required cv=0 id=6 cid=6", chosen_valid, pokemon_id, chosen_id);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (chosen_valid !== 1'b1 || chosen_id !== 8'd6) begin
      n_fails++;
      $display("FAIL confirm_30: cv=%0b cid=%0d, required cv=1 cid=6", chosen_valid, chosen_id);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    n_checks++;
    if (chosen_valid !== 1'b1 || pokemon_id !== 8'd6) begin
      n_fails++;
      $display("FAIL done_hold: cv=%0b id=%0d, required cv=1 id=6", chosen_valid, pokemon_id);
    end
    cyc(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (chosen_valid !== 1'b0 || chosen_id !== 8'd6 || pokemon_id !== 8'd6) begin
      n_fails++;
      $display("FAIL done_ack: cv=%0b cid=%0d id=%0d, required cv=0 cid=6 id=6", chosen_valid, chosen_id, pokemon_id);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd7) begin
      n_fails++;
      $display("FAIL rebrowse: id=%0d, required 7", pokemon_id);
    end
  endtask

  task automatic test_disable();
    int cv_seen = 0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    enable = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, i == 3, 0, 0, 0, i == 4, 1);
      if (chosen_valid !== 1'b0) cv_seen++;
    end
    n_checks++;
    if (cv_seen != 0 || highlight_on !== 1'b0 || pokemon_id !== 8'd7) begin
      n_fails++;
      $display("FAIL disable_confirm: cv_cycles=%0d hl=%0b id=%0d, required 0 0 7", cv_seen, highlight_on, pokemon_id);
    end
    enable = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pokemon_id !== 8'd7 || highlight_on !== 1'b1 || chosen_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reenable: id=%0d hl=%0b cv=%0b, required id=7 hl=1 cv=0", pokemon_id, highlight_on, chosen_valid);
    end
  endtask

  task automatic test_reset_in_done();
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < CONFIRM; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (chosen_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL reach_done: cv=%0b, required 1", chosen_valid);
    end
    rst_n = 0;
    cyc(1, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (pokemon_id !== 8'd1 || highlight_on !== 1'b0 || chosen_valid !== 1'b0 || chosen_id !== 8'd0) begin
      n_fails++;
      $display("FAIL reset_done: id=%0d hl=%0b cv=%0b cid=%0d, required 1 0 0 0",
               pokemon_id, highlight_on, chosen_valid, chosen_id);
    end
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 63) != 0);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0);
      n_checks++;
      if (pokemon_id !== 8'(m_id) || highlight_on !== m_hl || chosen_valid !== m_cv ||
          chosen_id !== 8'(m_cid) || pokemon_id < 8'd1 || pokemon_id > 8'd8) begin
        n_fails++;
        $display("FAIL random[%0d]: id=%0d hl=%0b cv=%0b cid=%0d, required id=%0d hl=%0b cv=%0b cid=%0d",
                 i, pokemon_id, highlight_on, chosen_valid, chosen_id, m_id, m_hl, m_cv, m_cid);
      end
    end
    rst_n = 1; enable = 1;
  endtask

  initial begin
    test_reset();
    test_browse();
    test_edges();
    test_blink();
    test_confirm();
    test_disable();
    test_reset_in_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pokemon_select_ctrl.md
POKEMON_SELECT_CTRL -- requirements
Module: pokemon_select_ctrl

Interface
REQ-001 SHALL have parameter BLINK_FRAMES, default 16, frame_tick count per highlight toggle while browsing (range 1..255).
REQ-002 SHALL have parameter CONFIRM_FRAMES, default 30, frame_tick count the CONFIRM state is held (range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  selection scene active.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 SHALL have ports btn_left, btn_right, btn_up, btn_down, btn_enter  input  1 each  debounced one-cycle press pulses.
REQ-008 SHALL have port chosen_ack  input  1  consumer accepts chosen_id.
REQ-009 SHALL have port pokemon_id  output  8  cursor slot, 8'd1..8'd8; 1-4 top row, 5-8 bottom row, left to right.
REQ-010 SHALL have port highlight_on  output  1  cursor box drawn this frame.
REQ-011 SHALL have port chosen_valid  output  1  selection complete, chosen_id stable.
REQ-012 SHALL have port chosen_id  output  8  confirmed slot, 8'd0 when none.

Function
REQ-013 SHALL implement states IDLE, BROWSE, CONFIRM, DONE; all outputs registered.
REQ-014 IDLE: enable=1 -> BROWSE next cycle; button pulses ignored.
REQ-015 BROWSE: a press updates pokemon_id on the clock edge that samples the pulse; new value visible the following cycle.
REQ-016 Same-cycle presses: priority enter > left > right > up > down; only the winner acts.
REQ-017 Left/right move by 1 within the current row; up/down move by 4 between rows (column preserved); up in top row and down in bottom row leave pokemon_id unchanged.
REQ-018 Left at column 1 and right at column 4: behaviour per REQ-027/REQ-028; never leave the row.
REQ-019 BROWSE: blink counter increments on frame_tick; on reaching BLINK_FRAMES-1 it clears and highlight_on toggles; any move press clears the counter and sets highlight_on=1.
REQ-020 Enter in BROWSE -> CONFIRM; chosen_id latches pokemon_id the same edge; highlight_on forced 1; frame counter cleared.
REQ-021 CONFIRM: buttons ignored; counter increments on frame_tick; after CONFIRM_FRAMES ticks -> DONE with chosen_valid=1.
REQ-022 DONE: chosen_valid and chosen_id held until chosen_ack=1 sampled; then chosen_valid=0 and state -> IDLE the next cycle; chosen_id retains value; pokemon_id unchanged.
REQ-023 chosen_ack outside DONE SHALL be ignored; chosen_ack and frame_tick in the same cycle: ack takes effect.
REQ-024 enable=0 in any state -> IDLE next cycle, chosen_valid=0, highlight_on=0, counters cleared, pokemon_id retained; this takes priority over all button, tick and ack events.
REQ-025 pokemon_id SHALL never take a value outside 1..8.

Reset
REQ-026 rst_n=0 at a clock edge: state IDLE, pokemon_id=8'd1, highlight_on=0, chosen_valid=0, chosen_id=8'd0, counters 0; takes priority over every other input, including mid-CONFIRM and mid-DONE.

Configuration
REQ-027 With SELECT_WRAP_EN defined: left at column 1 -> column 4 of same row; right at column 4 -> column 1 (e.g. 1->4, 8->5).
REQ-028 Without SELECT_WRAP_EN: left at column 1 and right at column 4 leave pokemon_id unchanged, but still clear the blink counter and set highlight_on=1.

Verification
REQ-029 Reset, enable=1, btn_right x3 then btn_down -> pokemon_id 2,3,4 then 8; chosen_valid=0 throughout.
REQ-030 pokemon_id=5, btn_left: with SELECT_WRAP_EN -> 8; without -> stays 5; btn_up at 5 -> 1, btn_up at 1 -> stays 1.
REQ-031 BLINK_FRAMES=4, hold BROWSE, 12 frame_ticks -> highlight_on toggles exactly 3 times; btn_right mid-count -> highlight_on=1, counter restarts.
REQ-032 pokemon_id=6, btn_enter with btn_left same cycle -> CONFIRM, chosen_id=6, pokemon_id stays 6; CONFIRM_FRAMES=30 ticks -> chosen_valid=1; chosen_ack pulse -> chosen_valid=0, IDLE.
REQ-033 In CONFIRM after 10 ticks drop enable -> IDLE next cycle, chosen_valid never asserts; re-enable -> BROWSE with pokemon_id unchanged.
REQ-034 rst_n=0 during DONE -> all outputs reset values per REQ-026 on the next edge, regardless of chosen_ack.
